// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared constants and types for the row-buffer sequencer
package pingpong_pkg;
  localparam int ROW_PIXELS = 8;
  typedef logic [2:0] col_t;
  function automatic int row_w(input int rows);
    return $clog2(rows);
  endfunction
endpackage

// File: rtl/pingpong_wrap_counter.sv
// wrap_counter: enabled up-counter with sync clear that wraps from MAX to 0
module wrap_counter #(
  parameter int MAX = 7,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : !en ? cnt_q : (cnt_q == W'(MAX)) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pingpong_ctrl.sv
// pingpong_ctrl: sequences an 8-pixel SIPO row buffer and hands completed rows downstream
module pingpong_ctrl
  import pingpong_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  output logic                      buf_ena,
  output logic                      buf_shiftout,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [row_w(ROWS)-1:0]    row_idx,
  output logic                      row_last,
  output logic [CNT_W-1:0]          blocks_done,
  output logic                      busy
);
  localparam int RW = row_w(ROWS);
  col_t          col;
  logic [RW-1:0] in_row;
  logic          last_col, acc, take;
  logic          row_valid_q, row_valid_d, row_last_q, row_last_d;
  logic [RW-1:0] row_idx_q, row_idx_d;
  logic [CNT_W-1:0] blocks_done_q, blocks_done_d;
  wrap_counter #(.MAX(ROW_PIXELS - 1), .W(3)) u_col (
    .clk(clk), .rst(rst), .clr(clear), .en(acc), .cnt(col)
  );
  wrap_counter #(.MAX(ROWS - 1), .W(RW)) u_row (
    .clk(clk), .rst(rst), .clr(clear), .en(buf_shiftout), .cnt(in_row)
  );
  // a final pixel may only load the buffer once the presented row is leaving
  always_comb begin
    last_col      = col == col_t'(ROW_PIXELS - 1);
    pix_ready     = !clear && !(last_col && row_valid_q && !row_ready);
    acc           = pix_valid && pix_ready;
    buf_ena       = acc;
    buf_shiftout  = acc && last_col;
    take          = row_valid_q && row_ready;
    row_valid_d   = clear ? 1'b0 : buf_shiftout ? 1'b1 : take ? 1'b0 : row_valid_q;
    row_idx_d     = clear ? '0 : buf_shiftout ? in_row : row_idx_q;
    row_last_d    = clear ? 1'b0 : buf_shiftout ? (in_row == RW'(ROWS - 1)) : row_last_q;
    blocks_done_d = (!clear && take && row_last_q) ? blocks_done_q + 1'b1 : blocks_done_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      row_valid_q   <= 1'b0;
      row_idx_q     <= '0;
      row_last_q    <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      row_valid_q   <= row_valid_d;
      row_idx_q     <= row_idx_d;
      row_last_q    <= row_last_d;
      blocks_done_q <= blocks_done_d;
    end
  assign row_valid   = row_valid_q;
  assign row_idx     = row_idx_q;
  assign row_last    = row_last_q;
  assign blocks_done = blocks_done_q;
  assign busy        = (col != '0) || (in_row != '0) || row_valid_q;
endmodule
